// File: rtl/signed_muldiv_sched_pkg.sv
// Shared types and widths for the signed multiply/divide scheduler.
package muldiv_sched_pkg;

    localparam int unsigned OPND_W = 8;
    localparam int unsigned RES_W  = 16;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/signed_muldiv_sched_if.sv
// Request/response bundle between client blocks and the muldiv scheduler.
interface signed_muldiv_sched_if
    import muldiv_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_op;
    logic [N_REQ*OPND_W-1:0] req_a;
    logic [N_REQ*OPND_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_op;
    logic [RES_W-1:0]        rsp_result;
    logic                    rsp_dbz;
    logic                    busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_op, rsp_result, rsp_dbz, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_op, rsp_result, rsp_dbz, busy
    );
endinterface

// File: rtl/muldiv_sched_arb.sv
// Request arbiter: fixed priority (index 0 highest) or, with MULDIV_SCHED_RR_EN, round-robin.
module muldiv_sched_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic             accept_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_idx_o
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] lo_idx, hi_idx;
    logic            lo_found, hi_found;

`ifdef MULDIV_SCHED_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (gnt_idx_o == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rst, accept_i};
    assign ptr        = '0;
`endif

    // Downward scan leaves the lowest valid index overall and the lowest at/after ptr.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        lo_found = 1'b0;
        hi_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[ID_W'(i)]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        gnt_idx_o = hi_found ? hi_idx : lo_idx;
        gnt_o     = lo_found ? (N_REQ'(1) << gnt_idx_o) : '0;
    end
endmodule

// File: rtl/signed_mult_div.sv
// Combinational 8-bit signed multiplier / truncating divider with divide-by-zero flag.
module signed_mult_div
    import muldiv_sched_pkg::*;
(
    input  logic signed [OPND_W-1:0] a,
    input  logic signed [OPND_W-1:0] b,
    output logic signed [RES_W-1:0]  product,
    output logic signed [OPND_W-1:0] quotient,
    output logic                     dbz
);
    logic signed [OPND_W:0] q_wide;

    always_comb begin
        product = RES_W'(a) * RES_W'(b);
        dbz     = (b == '0);
        // One extra bit so -128/-1 yields +128 and wraps to 8'h80 on truncation.
        q_wide  = '0;
        if (!dbz) begin
            q_wide = (OPND_W+1)'(a) / (OPND_W+1)'(b);
        end
        quotient = q_wide[OPND_W-1:0];
    end
endmodule

// File: rtl/signed_muldiv_sched.sv
// Shares one signed_mult_div among N_REQ requesters; MULDIV_SCHED_RR_EN selects round-robin.
module signed_muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_muldiv_sched_if.slave  bus
);
    state_e              state_q, state_d;
    logic [OPND_W-1:0]   opa_q, opa_d, opb_q, opb_d;
    op_e                 op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_op_q, rsp_op_d;
    logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
    logic                rsp_dbz_q, rsp_dbz_d;
    logic                busy_q, busy_d;

    logic [N_REQ-1:0]    gnt, req_ready;
    logic [ID_W-1:0]     gnt_idx;
    logic                accept;
    logic [OPND_W-1:0]   a_sel, b_sel;
    logic                op_sel;
    logic signed [RES_W-1:0]  product;
    logic signed [OPND_W-1:0] quotient;
    logic                dbz;

    muldiv_sched_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (bus.req_valid),
        .accept_i    (accept),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx)
    );

    signed_mult_div u_unit (
        .a        (opa_q),
        .b        (opb_q),
        .product  (product),
        .quotient (quotient),
        .dbz      (dbz)
    );

    always_comb begin
        req_ready = (state_q == IDLE && !rst) ? gnt : '0;
        accept    = |(bus.req_valid & req_ready);
        a_sel     = '0;
        b_sel     = '0;
        op_sel    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            a_sel  = a_sel | (bus.req_a[i*OPND_W +: OPND_W] & {OPND_W{gnt[i]}});
            b_sel  = b_sel | (bus.req_b[i*OPND_W +: OPND_W] & {OPND_W{gnt[i]}});
            op_sel = op_sel | (bus.req_op[i] & gnt[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_op_d     = rsp_op_q;
        rsp_result_d = rsp_result_q;
        rsp_dbz_d    = rsp_dbz_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d   = a_sel;
                    opb_d   = b_sel;
                    op_d    = op_e'(op_sel);
                    id_d    = gnt_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = (op_q == OP_DIV)
                             ? {{(RES_W-OPND_W){quotient[OPND_W-1]}}, quotient}
                             : product;
                rsp_dbz_d    = dbz && (op_q == OP_DIV);
                rsp_op_d     = op_q;
                rsp_id_d     = id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= OP_MUL;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_op_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_dbz_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_op_q     <= rsp_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_dbz_q    <= rsp_dbz_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_dbz    = rsp_dbz_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_signed_muldiv_sched.sv
// Directed bench for signed_muldiv_sched; expected ids follow MULDIV_SCHED_RR_EN when defined.
module tb_signed_muldiv_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    signed_muldiv_sched_if #(.N_REQ(4), .ID_W(2)) bus ();

    signed_muldiv_sched #(
        .N_REQ (4),
        .ID_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single request from requester idx; checks exact 2-edge latency and response fields.
    task automatic do_op(input int idx, input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] er, input logic edbz, input string tag);
        int n;
        bus.req_valid = '0;
        bus.req_valid[idx] = 1'b1;
        bus.req_op    = {4{op}};
        bus.req_a     = {4{a}};
        bus.req_b     = {4{b}};
        bus.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[idx] && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(4'b1 << idx));
        step();
        bus.req_valid = '0;
        #1;
        check({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_exec_nvalid"}, 32'(bus.rsp_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_result"}, 32'(bus.rsp_result), 32'(er));
        check({tag, "_dbz"}, 32'(bus.rsp_dbz), 32'(edbz));
        check({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
        check({tag, "_op"}, 32'(bus.rsp_op), 32'(op));
        step();
        check({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        int eid;
        bus.req_valid = 4'b1111;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset: every output low, grants suppressed even with requests pending.
        step();
        step();
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_result", 32'(bus.rsp_result), 32'd0);
        check("rst_id", 32'(bus.rsp_id), 32'd0);
        check("rst_dbz", 32'(bus.rsp_dbz), 32'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        step();
        check("idle_ready", 32'(bus.req_ready), 32'd0);

        do_op(0, 1'b0, 8'd127, 8'd127, 16'd16129, 1'b0, "mul_127");
        do_op(0, 1'b0, 8'h80, 8'h80, 16'h4000, 1'b0, "mul_m128sq");
        do_op(0, 1'b0, 8'd5, 8'd0, 16'h0000, 1'b0, "mul_by0");
        do_op(0, 1'b1, 8'(-10), 8'd5, 16'hFFFE, 1'b0, "div_m10_5");
        do_op(2, 1'b1, 8'd10, 8'(-5), 16'hFFFE, 1'b0, "div_10_m5");
        do_op(1, 1'b1, 8'h80, 8'hFF, 16'hFF80, 1'b0, "div_wrap");
        do_op(3, 1'b1, 8'd10, 8'd0, 16'h0000, 1'b1, "div_by0");
        do_op(0, 1'b1, 8'd7, 8'd2, 16'h0003, 1'b0, "div_7_2");

        // Back-pressure: response held while requester 0 keeps asking.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_op    = '0;
        bus.req_a     = {4{8'h80}};
        bus.req_b     = {4{8'd127}};
        step();
        bus.req_valid = 4'b0010;
        step();
        check("bp_valid0", 32'(bus.rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_result", 32'(bus.rsp_result), 32'h0000C080);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step();
        check("bp_release", 32'(bus.rsp_valid), 32'd0);
        check("bp_hold_result", 32'(bus.rsp_result), 32'h0000C080);

        // Contention from a clean pointer: all four held valid, a=i+1, b=3.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.req_b     = {4{8'd3}};
        bus.req_op    = '0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
`ifdef MULDIV_SCHED_RR_EN
            eid = k;
`else
            eid = 0;
`endif
            n = 0;
            while (!bus.rsp_valid && n < 10) begin
                step();
                n++;
            end
            check("cont_valid", 32'(bus.rsp_valid), 32'd1);
            check("cont_id", 32'(bus.rsp_id), 32'(eid));
            check("cont_result", 32'(bus.rsp_result), 32'((eid + 1) * 3));
            step();
        end
        bus.req_valid = '0;
        step();
        step();

        // Reset during EXEC drops the op and re-arbitrates cleanly.
        bus.req_valid = 4'b0010;
        bus.req_a     = {4{8'd9}};
        bus.req_b     = {4{8'd9}};
        #1;
        check("rmo_ready", 32'(bus.req_ready), 32'b0010);
        step();
        check("rmo_exec_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rmo_valid", 32'(bus.rsp_valid), 32'd0);
        check("rmo_busy", 32'(bus.busy), 32'd0);
        check("rmo_ready_after", 32'(bus.req_ready), 32'b0010);
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rmo_no_stale", 32'(bus.rsp_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signed_muldiv_sched.md
Name: signed_muldiv_sched

Overview:
- Shares one combinational signed_mult_div unit (8-bit signed a/b; 16-bit product, 8-bit quotient, div-by-zero flag) between N requesters.
- Each requester issues a multiply or divide over a valid/ready handshake.
- The scheduler arbitrates, registers operands, captures the result and returns it with the requester ID over a back-pressurable response channel.
- Sits between client blocks and the arithmetic datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal clog2(N_REQ) (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set.
- req_op  in  N_REQ  per-requester op: 0=multiply, 1=divide.
- req_a  in  N_REQ*8  flattened signed dividend/multiplicand; slice i = [8i+7:8i].
- req_b  in  N_REQ*8  flattened signed divisor/multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the served requester.
- rsp_op  out  1  echo of the served op.
- rsp_result  out  16  signed product, or quotient sign-extended to 16.
- rsp_dbz  out  1  divide-by-zero flag (divide ops only).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE; arbitration pointer goes to 0.
  - All outputs 0: rsp_valid, rsp_id, rsp_op, rsp_result, rsp_dbz, busy, req_ready.
  - Reset asserted mid-operation drops the in-flight op; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = one-hot grant, computed combinationally from req_valid and the pointer.
  - On an edge where req_valid[g] & req_ready[g]: latch a, b, op and id=g into operand registers; go to EXEC.
  - No valid requests: stay in IDLE; req_ready = 0.
- EXEC:
  - The unit sees the registered operands.
  - Next edge: capture rsp_result, rsp_dbz, rsp_op, rsp_id; go to RESP.
- RESP:
  - rsp_valid = 1; all response outputs are held stable until rsp_ready.
  - On the edge with rsp_valid & rsp_ready: go to IDLE.
  - Response registers keep their last value; only rsp_valid drops.
- Latency: accept edge E0, rsp_valid high after E1. Minimum 3 cycles per op (no overlap); req_ready is 0 outside IDLE.
- Requester rule: holds req_valid and operands stable until accepted. The scheduler never withdraws a grant within IDLE except on rst.
- Multiply: rsp_result = a*b, full 16-bit signed. -128*-128 = 16384 (16'h4000); rsp_dbz = 0.
- Divide:
  - Quotient truncates toward zero; it is sign-extended to 16 bits.
  - -128/-1 wraps to 8'h80, giving rsp_result 16'hFF80 (no trap).
  - b==0: rsp_result = 0, rsp_dbz = 1.
- Arbitration default: fixed priority, lowest index wins.

Optional Feature:
- Macro MULDIV_SCHED_RR_EN.
- Defined: round-robin.
  - Search starts at pointer p; after each accept, p = (g+1) mod N_REQ.
  - Reset sets p to 0.
- Undefined: fixed priority, requester 0 highest; the pointer logic is not built.

Decomposition:
- Package muldiv_sched_pkg holds:
  - op typedef (OP_MUL=0, OP_DIV=1)
  - FSM state enum (IDLE/EXEC/RESP)
  - operand width 8 and result width 16 constants
- Datapath: one instance of the existing signed_mult_div.
- One natural sub-module: muldiv_sched_arb (combinational grant; pointer register under MULDIV_SCHED_RR_EN).

Test Plan:
- Single mul: req0 valid, a=127, b=127, op=0; rsp_ready=1 -> req_ready[0] one cycle; rsp_valid 2 cycles after accept; rsp_result=16129, rsp_id=0, rsp_dbz=0.
- Divide cases:
  - a=-10, b=5 -> result 16'hFFFE.
  - a=10, b=-5 -> 16'hFFFE.
  - a=-128, b=-1 -> 16'hFF80.
  - a=10, b=0 -> result 0, rsp_dbz=1.
- Back-pressure: rsp_ready=0 for 5 cycles with a=-128, b=127 mul -> rsp_valid and result 16'hC080 held stable; req_ready=0 throughout; busy=1.
- Contention: all 4 requesters valid simultaneously.
  - Fixed priority: service order 0,0,... while req0 stays valid.
  - RR_EN: order 0,1,2,3, with rsp_id matching.
- Reset mid-op: assert rst during EXEC -> next cycle rsp_valid=0, busy=0, req_ready reflects fresh arbitration; no stale response ever appears.
